// File: rtl/spike_sum_threshold_pkg.sv
// spike_sum_threshold_pkg: NoC packet layout, type codes, mesh addresses, sizes, FSM states and saturating add
package spike_sum_threshold_pkg;
    localparam int WIDTH    = 35;
    localparam int NUM_PSUM = 10;
    localparam int PSUM_W   = 12;
    localparam int MP_W     = 16;
    localparam int ACC_W    = PSUM_W + 4;
    localparam int OMAP     = 28;
    localparam int SLOTS    = 3;
    localparam int DEPTH    = OMAP * OMAP;
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int SRC_LSB  = 31;
    localparam int DST_LSB  = 27;
    localparam int TYPE_LSB = 24;
    localparam int SLOT_LSB = 22;
    localparam logic signed [MP_W-1:0] THRESH = 16'sd64;
    localparam logic signed [MP_W-1:0] MP_MAX = {1'b0, {(MP_W-1){1'b1}}};
    localparam logic signed [MP_W-1:0] MP_MIN = {1'b1, {(MP_W-1){1'b0}}};
    localparam logic [3:0] MY_ADDR  = 4'b0100;
    localparam logic [3:0] IFM_ADDR = 4'b0000;
    localparam logic [3:0] OUT_ADDR = 4'b0011;
    localparam logic [2:0] TYPE_IFM  = 3'b001;
    localparam logic [2:0] TYPE_PSUM = 3'b010;
    localparam logic [2:0] TYPE_SPK  = 3'b011;
    localparam logic [2:0] TYPE_DONE = 3'b100;
    typedef enum logic [2:0] {CLEAR, COLLECT, UPDATE, SEND_SPK, SEND_DONE, FINISHED} state_t;
    // One extra bit catches overflow; clamp to the MP_W range instead of wrapping
    function automatic logic signed [MP_W-1:0] sat_add(input logic signed [MP_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
        logic signed [MP_W:0] s;
        s = (MP_W+1)'(a) + (MP_W+1)'(b);
        return (s[MP_W] != s[MP_W-1]) ? (s[MP_W] ? MP_MIN : MP_MAX) : s[MP_W-1:0];
    endfunction
endpackage

// File: rtl/spike_sum_threshold_if.sv
// spike_sum_threshold_if: NoC ingress/egress valid-ready streams; master = NoC side, slave = neuron stage
interface spike_sum_threshold_if;
    import spike_sum_threshold_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/spike_sum_threshold_membrane_mem.sv
// membrane_mem: 784 x MP_W membrane potentials; ports clk, we/addr/wdata sync write, rdata combinational read of addr
module membrane_mem
    import spike_sum_threshold_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [MP_W-1:0]   wdata,
    output logic [MP_W-1:0]   rdata
);
    logic [MP_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/spike_sum_threshold.sv
// spike_sum_threshold: integrate-and-fire stage; ports clk, rst_n, bus (psum in / spike+done out), all_done, drop_err
module spike_sum_threshold
    import spike_sum_threshold_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    spike_sum_threshold_if.slave bus,
    output logic                 all_done,
    output logic                 drop_err
);
    state_t                    state, state_nx;
    logic [ADDR_W-1:0]         clr_idx, mem_addr, upd_addr;
    logic [3:0]                psum_cnt;
    logic [1:0]                upd_slot, in_slot;
    logic signed [ACC_W-1:0]   acc [SLOTS];
    logic signed [ACC_W-1:0]   acc_sel, in_psum;
    logic [SLOTS-1:0]          spike;
    logic                      ts;
    logic [4:0]                row, col_base, upd_col;
    logic [3:0]                in_dst;
    logic [2:0]                in_type;
    logic                      hs, pkt_ok, slot_use, last_psum, upd_use, fire, mem_we;
    logic                      step_done, col_end, row_end;
    logic signed [MP_W-1:0]    mem_rd, mp_next;
    logic [MP_W-1:0]           mem_wd;
    logic                      unused_bits;
    assign in_dst      = bus.in_data[DST_LSB +: 4];
    assign in_type     = bus.in_data[TYPE_LSB +: 3];
    assign in_slot     = bus.in_data[SLOT_LSB +: 2];
    assign in_psum     = ACC_W'($signed(bus.in_data[PSUM_W-1:0]));
    assign unused_bits = ^{bus.in_data[SRC_LSB +: 4], bus.in_data[SLOT_LSB-1:PSUM_W]};
    assign hs          = bus.in_valid && bus.in_ready;
    assign pkt_ok      = in_dst == MY_ADDR && in_type == TYPE_PSUM && in_slot != 2'd3;
    // Slots past the right edge of the map are counted but their value is dropped
    assign slot_use    = col_base + 5'(in_slot) <= 5'(OMAP-1);
    assign last_psum   = hs && pkt_ok && psum_cnt == 4'(NUM_PSUM-1);
    assign upd_col     = col_base + 5'(upd_slot);
    assign upd_use     = upd_col <= 5'(OMAP-1);
    assign upd_addr    = ADDR_W'(row) * ADDR_W'(OMAP) + ADDR_W'(upd_col);
    assign acc_sel     = upd_slot == 2'd0 ? acc[0] : upd_slot == 2'd1 ? acc[1] : acc[2];
    assign mp_next     = sat_add(mem_rd, acc_sel);
    assign fire        = upd_use && mp_next >= THRESH;
    assign mem_we      = state == CLEAR || (state == UPDATE && upd_use);
    // Unusable edge slots would index past the row (or the array); park the port on 0
    assign mem_addr    = state == CLEAR ? clr_idx : upd_use ? upd_addr : '0;
    assign mem_wd      = (state == CLEAR || fire) ? '0 : mp_next;
    assign step_done   = state == SEND_DONE && bus.out_ready;
    assign col_end     = col_base == 5'(OMAP-1);
    assign row_end     = row == 5'(OMAP-1);
    membrane_mem u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wd),
        .rdata (mem_rd)
    );
    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:     state_nx = clr_idx == ADDR_W'(DEPTH-1) ? COLLECT : CLEAR;
            COLLECT:   state_nx = last_psum ? UPDATE : COLLECT;
            UPDATE:    state_nx = upd_slot == 2'(SLOTS-1) ? SEND_SPK : UPDATE;
            SEND_SPK:  state_nx = bus.out_ready ? SEND_DONE : SEND_SPK;
            SEND_DONE: state_nx = !step_done ? SEND_DONE : (col_end && row_end && ts) ? FINISHED : COLLECT;
            default:   state_nx = state;
        endcase
    end
    assign bus.in_ready  = state == COLLECT;
    assign bus.out_valid = state == SEND_SPK || state == SEND_DONE;
    assign bus.out_data  = state == SEND_SPK  ? {MY_ADDR, OUT_ADDR, TYPE_SPK, ts, row, col_base, 10'b0, spike} :
                           state == SEND_DONE ? {MY_ADDR, IFM_ADDR, TYPE_DONE, 24'b0} : '0;
    assign all_done      = state == FINISHED;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_idx  <= '0;
            psum_cnt <= '0;
            upd_slot <= '0;
            spike    <= '0;
            ts       <= 1'b0;
            row      <= '0;
            col_base <= '0;
            drop_err <= 1'b0;
            for (int s = 0; s < SLOTS; s++) acc[s] <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
            if (hs && !pkt_ok) drop_err <= 1'b1;
            if (hs && pkt_ok) psum_cnt <= last_psum ? '0 : psum_cnt + 1'b1;
            for (int s = 0; s < SLOTS; s++)
                if (hs && pkt_ok && slot_use && in_slot == 2'(s)) acc[s] <= acc[s] + in_psum;
            if (state == UPDATE) begin
                for (int s = 0; s < SLOTS; s++)
                    if (upd_slot == 2'(s)) spike[s] <= fire;
                upd_slot <= upd_slot == 2'(SLOTS-1) ? '0 : upd_slot + 1'b1;
                if (upd_slot == 2'(SLOTS-1))
                    for (int s = 0; s < SLOTS; s++) acc[s] <= '0;
            end
            if (step_done) begin
                col_base <= col_end ? '0 : col_base + 5'(SLOTS);
                if (col_end) begin
                    row <= row_end ? '0 : row + 1'b1;
                    if (row_end) ts <= ~ts;
                end
            end
        end
    end
endmodule
